dcache_line_controller: RTL and testbench



---
 rtl/xentry_pkg.sv | 18 +
 rtl/dcache_line_controller_if.sv | 54 +++++
 rtl/xentry_beat_counter.sv | 34 +++
 rtl/dcache_line_controller.sv | 191 +++++++++++++++++++
 tb/tb_dcache_line_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xentry_pkg.sv
// Shared types for the dcache line controller slice.
// Exposes the L2 operation and controller state encodings.
package xentry_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WRITEBACK   = 3'd1,
    ST_REFILL      = 3'd2,
    ST_SWEEP_CHECK = 3'd3,
    ST_SWEEP_WB    = 3'd4
  } dcache_ctrl_state_e;

endpackage

// File: rtl/dcache_line_controller_if.sv
// Datapath / L2 signal bundle for the dcache line controller.
// master = controller side, slave = datapath and L2 side.
interface dcache_line_controller_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 16
);
  import xentry_pkg::*;

  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE);
  localparam int SET_IDX_W  = $clog2(NUM_SETS);

  logic cpu_req_valid;
  logic hit;
  logic dirty_miss;
  logic clean_miss;
  logic flush_all_req;
  logic sweep_dirty;
  logic l2_word_valid;

  logic                  l2_req_valid;
  memory_operation_e     l2_req_type;
  logic [WORD_IDX_W-1:0] word_index;
  logic [SET_IDX_W-1:0]  sweep_set;
  logic                  flush_mode;
  logic                  load_mode;
  logic                  sweep_mode;
  logic                  set_new_l2_block_address;
  logic                  clear_selected_dirty_bit;
  logic                  clear_selected_valid_bit;
  logic                  finish_new_line_install;
  logic                  flush_all_done;
  logic                  busy;

  modport master (
    input  cpu_req_valid, hit, dirty_miss, clean_miss,
    input  flush_all_req, sweep_dirty, l2_word_valid,
    output l2_req_valid, l2_req_type, word_index, sweep_set,
    output flush_mode, load_mode, sweep_mode,
    output set_new_l2_block_address, clear_selected_dirty_bit,
    output clear_selected_valid_bit, finish_new_line_install,
    output flush_all_done, busy
  );

  modport slave (
    output cpu_req_valid, hit, dirty_miss, clean_miss,
    output flush_all_req, sweep_dirty, l2_word_valid,
    input  l2_req_valid, l2_req_type, word_index, sweep_set,
    input  flush_mode, load_mode, sweep_mode,
    input  set_new_l2_block_address, clear_selected_dirty_bit,
    input  clear_selected_valid_bit, finish_new_line_install,
    input  flush_all_done, busy
  );

endinterface

// File: rtl/xentry_beat_counter.sv
// Clearable up-counter with all-ones terminal count.
// Clear has priority over increment.
module xentry_beat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = &cnt_q;

endmodule

// File: rtl/dcache_line_controller.sv
// Dcache miss/flush sequencer: write-back, refill and flush-all sweep.
// Pulses are Mealy; request and mode outputs are Moore.
module dcache_line_controller
  import xentry_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 16
) (
  input  logic clk,
  input  logic reset_n,
  dcache_line_controller_if.master bus
);

  localparam int WORD_IDX_W = $clog2(WORDS_PER_LINE);
  localparam int SET_IDX_W  = $clog2(NUM_SETS);

  dcache_ctrl_state_e state_q, state_d;

  logic w_clr, w_inc, w_tc;
  logic s_clr, s_inc, s_tc;
  logic advance;
  logic [WORD_IDX_W-1:0] w_cnt;
  logic [SET_IDX_W-1:0]  s_cnt;

  logic req_valid, fm, lm, sm;
  logic sa, cd, cv, fin, done, busy_w;
  memory_operation_e req_type;

  xentry_beat_counter #(.WIDTH(WORD_IDX_W)) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (w_clr),
    .inc_i   (w_inc),
    .cnt_o   (w_cnt),
    .tc_o    (w_tc)
  );

  xentry_beat_counter #(.WIDTH(SET_IDX_W)) u_set_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (s_clr),
    .inc_i   (s_inc),
    .cnt_o   (s_cnt),
    .tc_o    (s_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    req_type  = LOAD;
    fm        = 1'b0;
    lm        = 1'b0;
    sm        = 1'b0;
    sa        = 1'b0;
    cd        = 1'b0;
    cv        = 1'b0;
    fin       = 1'b0;
    done      = 1'b0;
    busy_w    = (state_q != ST_IDLE);
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    s_clr     = 1'b0;
    s_inc     = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req_valid && bus.hit) begin
          state_d = ST_IDLE;
        end else if (bus.cpu_req_valid && bus.dirty_miss) begin
          state_d = ST_WRITEBACK;
          sa      = 1'b1;
          w_clr   = 1'b1;
        end else if (bus.cpu_req_valid && bus.clean_miss) begin
          state_d = ST_REFILL;
          sa      = 1'b1;
          w_clr   = 1'b1;
        end else if (bus.flush_all_req) begin
          state_d = ST_SWEEP_CHECK;
          s_clr   = 1'b1;
        end
      end

      ST_WRITEBACK: begin
        req_valid = 1'b1;
        req_type  = STORE;
        fm        = 1'b1;
        if (bus.l2_word_valid) begin
          if (w_tc) begin
            cd      = 1'b1;
            cv      = 1'b1;
            sa      = 1'b1;
            w_clr   = 1'b1;
            state_d = ST_REFILL;
          end else begin
            w_inc = 1'b1;
          end
        end
      end

      ST_REFILL: begin
        req_valid = 1'b1;
        lm        = 1'b1;
        if (bus.l2_word_valid) begin
          if (w_tc) begin
            fin     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w_inc = 1'b1;
          end
        end
      end

      ST_SWEEP_CHECK: begin
        sm = 1'b1;
        if (bus.sweep_dirty) begin
          sa      = 1'b1;
          w_clr   = 1'b1;
          state_d = ST_SWEEP_WB;
        end else begin
          cv      = 1'b1;
          advance = 1'b1;
        end
      end

      ST_SWEEP_WB: begin
        req_valid = 1'b1;
        req_type  = STORE;
        fm        = 1'b1;
        sm        = 1'b1;
        if (bus.l2_word_valid) begin
          if (w_tc) begin
            cd      = 1'b1;
            cv      = 1'b1;
            advance = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end

      default: begin
        state_d   = dcache_ctrl_state_e'('x);
        req_valid = 1'bx;
        req_type  = memory_operation_e'('x);
        fm        = 1'bx;
        lm        = 1'bx;
        sm        = 1'bx;
        sa        = 1'bx;
        cd        = 1'bx;
        cv        = 1'bx;
        fin       = 1'bx;
        done      = 1'bx;
        busy_w    = 1'bx;
      end
    endcase

    // Shared end-of-set step for both sweep states
    if (advance) begin
      if (s_tc) begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end else begin
        s_inc   = 1'b1;
        state_d = ST_SWEEP_CHECK;
      end
    end
  end

  assign bus.l2_req_valid             = req_valid;
  assign bus.l2_req_type              = req_type;
  assign bus.word_index               = w_cnt;
  assign bus.sweep_set                = s_cnt;
  assign bus.flush_mode               = fm;
  assign bus.load_mode                = lm;
  assign bus.sweep_mode               = sm;
  assign bus.set_new_l2_block_address = sa;
  assign bus.clear_selected_dirty_bit = cd;
  assign bus.clear_selected_valid_bit = cv;
  assign bus.finish_new_line_install  = fin;
  assign bus.flush_all_done           = done;
  assign bus.busy                     = busy_w;

endmodule

// File: tb/tb_dcache_line_controller.sv
// Scoreboard bench for dcache_line_controller (4 words, 4 sets).
// Expected pulse/beat events are queued; a negedge monitor compares.
module tb_dcache_line_controller;
  import xentry_pkg::*;

  localparam int WPL  = 4;
  localparam int SETS = 4;

  typedef struct packed {
    logic       st;
    logic [1:0] wi;
    logic [1:0] ss;
    logic       fm, lm, sm, sa, cd, cv, fin, dn;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [SETS-1:0] dirty_mask = '0;
  int n_cmp = 0;
  int n_fail = 0;
  int onehot_viol = 0;
  ev_t q[$];

  dcache_line_controller_if #(.WORDS_PER_LINE(WPL), .NUM_SETS(SETS)) bus ();

  dcache_line_controller #(.WORDS_PER_LINE(WPL), .NUM_SETS(SETS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.sweep_dirty = dirty_mask[bus.sweep_set];

  function automatic ev_t mk(bit st, int wi, int ss, bit fm, bit lm,
                             bit sm, bit sa, bit cd, bit cv,
                             bit fin, bit dn);
    ev_t e;
    e.st = st; e.wi = wi[1:0]; e.ss = ss[1:0];
    e.fm = fm; e.lm = lm; e.sm = sm; e.sa = sa;
    e.cd = cd; e.cv = cv; e.fin = fin; e.dn = dn;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit cv, bit h, bit dm, bit cm, bit fl, bit wv);
    bus.cpu_req_valid = cv;
    bus.hit           = h;
    bus.dirty_miss    = dm;
    bus.clean_miss    = cm;
    bus.flush_all_req = fl;
    bus.l2_word_valid = wv;
  endtask

  always @(negedge clk) begin
    ev_t act;
    ev_t exp;
    logic evt;
    if (reset_n) begin
      if (bus.cpu_req_valid &&
          !$onehot({bus.hit, bus.dirty_miss, bus.clean_miss}))
        onehot_viol++;
      act = {logic'(bus.l2_req_type), bus.word_index, bus.sweep_set,
             bus.flush_mode, bus.load_mode, bus.sweep_mode,
             bus.set_new_l2_block_address,
             bus.clear_selected_dirty_bit,
             bus.clear_selected_valid_bit,
             bus.finish_new_line_install, bus.flush_all_done};
      evt = (bus.l2_req_valid & bus.l2_word_valid) | act.sa | act.cd
          | act.cv | act.fin | act.dn;
      if (evt) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
          exp = q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL event @%0t: got %h expected %h",
                     $time, act, exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #22 reset_n = 1'b1;
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_valid", bus.l2_req_valid, 0);
    chk("rst_req_type", int'(bus.l2_req_type), int'(LOAD));
    chk("rst_word_index", bus.word_index, 0);
    chk("rst_sweep_set", bus.sweep_set, 0);
    chk("rst_state", int'(dut.state_q), int'(ST_IDLE));

    // Clean miss, beats every cycle
    drive(1, 0, 0, 1, 0, 1);
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      drive(0, 0, 0, 0, 0, 1);
      q.push_back(mk(0, k, 0, 0, 1, 0, 0, 0, 0, k == 3, 0));
      #1 chk("refill_load_mode", bus.load_mode, 1);
    end
    step();
    drive(0, 0, 0, 0, 0, 1);
    #1 chk("clean_busy_end", bus.busy, 0);
    chk("clean_state_end", int'(dut.state_q), int'(ST_IDLE));

    // Dirty miss, l2_word_valid toggling
    step();
    drive(1, 0, 1, 0, 0, 0);
    q.push_back(mk(0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int c = 1; c <= 15; c++) begin
      bit wv;
      step();
      wv = (c % 2) == 1;
      drive(0, 0, 0, 0, 0, wv);
      if (wv) begin
        if (c < 8)
          q.push_back(mk(1, (c - 1) / 2, 0, 1, 0, 0,
                         c == 7, c == 7, c == 7, 0, 0));
        else
          q.push_back(mk(0, (c - 9) / 2, 0, 0, 1, 0,
                         0, 0, 0, c == 15, 0));
      end
      if (c == 2) begin
        #1 chk("stall_word_index", bus.word_index, 1);
        chk("wb_req_type", int'(bus.l2_req_type), int'(STORE));
      end
      if (c == 15) #1 chk("dirty_busy_last", bus.busy, 1);
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("dirty_busy_end", bus.busy, 0);

    // Flush-all with dirty sets 1 and 3
    dirty_mask = 4'b1010;
    step();
    drive(0, 0, 0, 0, 1, 1);
    for (int c = 1; c <= 12; c++) begin
      step();
      drive(0, 0, 0, 0, 0, 1);
      if (c == 1)
        q.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      else if (c == 2)
        q.push_back(mk(0, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      else if (c <= 6)
        q.push_back(mk(1, c - 3, 1, 1, 0, 1, 0,
                       c == 6, c == 6, 0, 0));
      else if (c == 7)
        q.push_back(mk(0, 3, 2, 0, 0, 1, 0, 0, 1, 0, 0));
      else if (c == 8)
        q.push_back(mk(0, 3, 3, 0, 0, 1, 1, 0, 0, 0, 0));
      else
        q.push_back(mk(1, c - 9, 3, 1, 0, 1, 0,
                       c == 12, c == 12, 0, c == 12));
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("flush_busy_end", bus.busy, 0);
    chk("flush_sweep_set", bus.sweep_set, 3);
    chk("flush_state_end", int'(dut.state_q), int'(ST_IDLE));

    // Flush and clean miss together: miss first
    dirty_mask = '0;
    step();
    drive(1, 0, 0, 1, 1, 1);
    q.push_back(mk(0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      drive(0, 0, 0, 0, 1, 1);
      q.push_back(mk(0, k, 3, 0, 1, 0, 0, 0, 0, k == 3, 0));
    end
    step();
    drive(0, 0, 0, 0, 1, 1);
    #1 chk("miss_then_idle", bus.busy, 0);
    for (int s = 0; s < 4; s++) begin
      step();
      drive(0, 0, 0, 0, 0, 1);
      q.push_back(mk(0, 3, s, 0, 0, 1, 0, 0, 1, 0, s == 3));
    end
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("sweep2_busy_end", bus.busy, 0);

    // Reset during refill beat 2
    step();
    drive(1, 0, 0, 1, 0, 1);
    q.push_back(mk(0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      step();
      drive(0, 0, 0, 0, 0, 1);
      q.push_back(mk(0, k, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    step();
    drive(0, 0, 0, 0, 0, 1);
    #1 chk("pre_rst_word_index", bus.word_index, 2);
    #1 reset_n = 1'b0;
    #1 chk("arst_req_valid", bus.l2_req_valid, 0);
    chk("arst_load_mode", bus.load_mode, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_word_index", bus.word_index, 0);
    chk("arst_sweep_set", bus.sweep_set, 0);
    chk("arst_finish", bus.finish_new_line_install, 0);
    chk("arst_set_addr", bus.set_new_l2_block_address, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("hit_busy", bus.busy, 0);
    chk("hit_state", int'(dut.state_q), int'(ST_IDLE));

    // Non-one-hot hit+dirty_miss behaves as hit
    step();
    drive(1, 1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("hit_dirty_busy", bus.busy, 0);
    chk("hit_dirty_req", bus.l2_req_valid, 0);
    step();
    step();
    chk("leftover_expected", q.size(), 0);
    chk("onehot_flagged", onehot_viol, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
